// File: rtl/prio_enc_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined priority encoder tree.
// Offsets place every tree level in one flat vector so each level is sized exactly to its node count.
package prio_enc_pkg;

  localparam int MAX_WIDTH  = 256;
  localparam int NODE_ANY   = 1;
  localparam int NODE_MULTI = 1;

  function automatic int clog4(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 4) r++;
    return r;
  endfunction

  // Index width produced by tree level l (1-based).
  function automatic int lvl_idx_w(input int l);
    return 2 * l;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 4) && (w <= MAX_WIDTH) && ((1 << (2 * clog4(w))) == w);
  endfunction

  // Merge nodes in tree level l (0-based).
  function automatic int lvl_nodes(input int w, input int l);
    return w >> (2 * (l + 1));
  endfunction

  function automatic int any_off(input int w, input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) s += lvl_nodes(w, k) * NODE_ANY;
    return s;
  endfunction

  function automatic int idx_off(input int w, input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) s += lvl_nodes(w, k) * lvl_idx_w(k + 1);
    return s;
  endfunction

endpackage

// File: rtl/prio_enc_node4.sv
// Combinational 4:1 merge node: picks the highest or lowest child with a request and prefixes its slot number.
// Zero latency; no flow control of its own.
module prio_enc_node4
  import prio_enc_pkg::*;
#(
  parameter int  CHILD_IDX_W = 0,
  localparam int CIW_S       = (CHILD_IDX_W == 0) ? 1 : CHILD_IDX_W,
  localparam int P_W         = CHILD_IDX_W + 2
) (
  input  logic               sel_lsb_first,
  input  logic [3:0]         c_any,
  input  logic [3:0]         c_multi,
  input  logic [4*CIW_S-1:0] c_idx,
  output logic               p_any,
  output logic               p_multi,
  output logic [P_W-1:0]     p_idx
);

  logic [1:0] w;
  logic [2:0] cnt;

  always_comb begin
    w = 2'd0;
    if (sel_lsb_first) begin
      for (int k = 3; k >= 0; k--) if (c_any[k]) w = 2'(k);
    end else begin
      for (int k = 0; k < 4; k++) if (c_any[k]) w = 2'(k);
    end
    cnt = {2'b0, c_any[0]} + {2'b0, c_any[1]} + {2'b0, c_any[2]} + {2'b0, c_any[3]};
    p_any   = |c_any;
    p_multi = (|c_multi) | (cnt >= 3'd2);
  end

  if (CHILD_IDX_W == 0) begin : g_leaf
    logic unused_idx;
    assign unused_idx = ^c_idx;
    assign p_idx      = p_any ? w : 2'b00;
  end else begin : g_inner
    logic [CHILD_IDX_W-1:0] c_sel;
    assign c_sel = c_idx[int'(w)*CHILD_IDX_W +: CHILD_IDX_W];
    assign p_idx = p_any ? {w, c_sel} : '0;
  end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Pipelined radix-4 priority encoder: one register bank per tree level, LEVELS cycles of latency, 1 vector/cycle.
// Backpressure: a single enable (!out_valid | out_ready) advances or freezes every stage, bubbles included.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter int  WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_req,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_any,
  output logic             out_multi
);

  localparam int LEVELS  = clog4(WIDTH);
  localparam int ANY_TOT = any_off(WIDTH, LEVELS);
  localparam int IDX_TOT = idx_off(WIDTH, LEVELS);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("prio_encoder_pipe: WIDTH must be a power of 4 in 4..256");
  end

  logic               en;
  logic [LEVELS-1:0]  vld_d, vld_q;
  logic [LEVELS-1:0]  lsb_d, lsb_q;
  logic [ANY_TOT-1:0] any_d, any_q;
  logic [ANY_TOT-1:0] multi_d, multi_q;
  logic [IDX_TOT-1:0] idx_d, idx_q;

  // The last stage's direction bit has no consumer; it exists only to keep the shift uniform.
  logic unused_lsb;
  assign unused_lsb = lsb_q[LEVELS-1];

  assign en       = !vld_q[LEVELS-1] | out_ready;
  assign in_ready = en;

  always_comb begin
    vld_d    = '0;
    lsb_d    = '0;
    vld_d[0] = in_valid;
    lsb_d[0] = in_lsb_first;
    for (int l = 1; l < LEVELS; l++) begin
      vld_d[l] = vld_q[l-1];
      lsb_d[l] = lsb_q[l-1];
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N   = lvl_nodes(WIDTH, l);
    localparam int CW  = lvl_idx_w(l);
    localparam int AO  = any_off(WIDTH, l);
    localparam int IO  = idx_off(WIDTH, l);
    localparam int PAO = any_off(WIDTH, l - 1);
    localparam int PIO = idx_off(WIDTH, l - 1);

    for (genvar n = 0; n < N; n++) begin : g_node
      logic [3:0]                        c_any;
      logic [3:0]                        c_multi;
      logic [4*((CW == 0) ? 1 : CW)-1:0] c_idx;
      logic                              sel;

      if (l == 0) begin : g_src_req
        assign c_any   = in_req[4*n +: 4];
        assign c_multi = 4'b0000;
        assign c_idx   = '0;
        assign sel     = in_lsb_first;
      end else begin : g_src_reg
        assign c_any   = any_q[PAO + 4*n +: 4];
        assign c_multi = multi_q[PAO + 4*n +: 4];
        assign c_idx   = idx_q[PIO + 4*n*CW +: 4*CW];
        assign sel     = lsb_q[l-1];
      end

      prio_enc_node4 #(
        .CHILD_IDX_W (CW)
      ) u_node (
        .sel_lsb_first (sel),
        .c_any         (c_any),
        .c_multi       (c_multi),
        .c_idx         (c_idx),
        .p_any         (any_d[AO + n]),
        .p_multi       (multi_d[AO + n]),
        .p_idx         (idx_d[IO + n*(CW+2) +: CW+2])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      lsb_q   <= '0;
      any_q   <= '0;
      multi_q <= '0;
      idx_q   <= '0;
    end else if (en) begin
      vld_q   <= vld_d;
      lsb_q   <= lsb_d;
      any_q   <= any_d;
      multi_q <= multi_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = vld_q[LEVELS-1];
  assign out_any   = any_q[ANY_TOT-1];
  assign out_multi = multi_q[ANY_TOT-1];
  assign out_idx   = idx_q[IDX_TOT-1 -: IDX_W];

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe at WIDTH=16 and WIDTH=64, scoreboarded against a bit-scan reference.
module tb_prio_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_lsb_first;
  logic [15:0] in_req;
  logic        out_valid, out_ready, out_any, out_multi;
  logic [3:0]  out_idx;

  logic        in_valid64, in_ready64, lsb64;
  logic [63:0] req64;
  logic        out_valid64, out_ready64, any64, multi64;
  logic [5:0]  idx64;

  int          nvec = 0;
  int          nerr = 0;
  logic [9:0]  exp_q[$];
  logic        xfer_in;
  logic        hold_chk = 1'b0;
  logic [3:0]  held_idx;

  always #5 clk = ~clk;

  prio_encoder_pipe #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_req       (in_req),
    .in_lsb_first (in_lsb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_any      (out_any),
    .out_multi    (out_multi)
  );

  prio_encoder_pipe #(.WIDTH(64)) dut64 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid64),
    .in_ready     (in_ready64),
    .in_req       (req64),
    .in_lsb_first (lsb64),
    .out_valid    (out_valid64),
    .out_ready    (out_ready64),
    .out_idx      (idx64),
    .out_any      (any64),
    .out_multi    (multi64)
  );

  // Reference: scan the vector, count set bits, remember the first (lsb) or last (msb) set position.
  // Result packing: [9] multi, [8] any, [7:0] index.
  function automatic logic [9:0] ref_enc(input logic [63:0] req, input int w, input logic lsb);
    int cnt;
    int win;
    cnt = 0;
    win = 0;
    for (int i = 0; i < w; i++) begin
      if (req[i]) begin
        cnt++;
        if (!lsb || cnt == 1) win = i;
      end
    end
    return {cnt > 1, cnt > 0, 8'(win)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample and score at the falling edge, then advance past the rising edge.
  task automatic step();
    logic       rs;
    logic [9:0] e;
    @(negedge clk);
    rs      = rst;
    xfer_in = 1'b0;
    if (!rs) begin
      if (hold_chk) begin
        chk("hold_idx", out_idx, held_idx);
        chk("hold_vld", out_valid, 1);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_idx", out_idx, e[7:0]);
          chk("out_any", out_any, e[8]);
          chk("out_multi", out_multi, e[9]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_enc({48'b0, in_req}, 16, in_lsb_first));
        xfer_in = 1'b1;
      end
      hold_chk = out_valid && !out_ready;
      held_idx = out_idx;
    end else begin
      hold_chk = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rs) exp_q.delete();
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic single(input logic [15:0] req, input logic lsb, input string tag);
    int n;
    in_req       = req;
    in_lsb_first = lsb;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_accept"}, xfer_in, 1);
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 2);
    step();
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run64(input logic [63:0] req, input logic lsb, input string tag);
    int         n;
    logic [9:0] e;
    e          = ref_enc(req, 64, lsb);
    req64      = req;
    lsb64      = lsb;
    in_valid64 = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready64, 1);
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    n = 1;
    while (!out_valid64 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_idx"}, idx64, e[7:0]);
    chk({tag, "_any"}, any64, e[8]);
    chk({tag, "_multi"}, multi64, e[9]);
    @(posedge clk);
    #1;
    chk({tag, "_gone"}, out_valid64, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_req       = '0;
    in_lsb_first = 1'b0;
    out_ready    = 1'b1;
    in_valid64   = 1'b0;
    req64        = '0;
    lsb64        = 1'b0;
    out_ready64  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_any", out_any, 0);
    chk("rst_out_multi", out_multi, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid64", out_valid64, 0);

    // Single vector, then one-hot sweep in both directions
    single(16'h0100, 1'b0, "onehot8");
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      v = 16'h0001 << i;
      single(v, 1'(i), "sweep");
    end

    // Back-to-back mixed-direction multi-hot vectors
    in_valid = 1'b1;
    in_req = 16'h8421; in_lsb_first = 1'b0; step();
    in_req = 16'h8421; in_lsb_first = 1'b1; step();
    in_req = 16'h0030; in_lsb_first = 1'b0; step();
    in_req = 16'h0030; in_lsb_first = 1'b1; step();
    in_valid = 1'b0;
    drain("b2b_drain");

    // All-zero request is still a transaction
    single(16'h0000, 1'b0, "zero");
    single(16'h0000, 1'b1, "zero_lsb");

    // Stream 6 vectors with the consumer stalled for 4 cycles starting at cycle 3
    cnt          = 0;
    in_req       = 16'($urandom);
    in_lsb_first = 1'($urandom);
    for (int c = 0; c < 40 && (cnt < 6 || exp_q.size() != 0); c++) begin
      out_ready = !(c >= 3 && c < 7);
      in_valid  = (cnt < 6);
      step();
      if (xfer_in) begin
        cnt++;
        in_req       = 16'($urandom);
        in_lsb_first = 1'($urandom);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", cnt, 6);
    chk("stream_drain", exp_q.size(), 0);

    // Reset with two vectors in flight
    in_valid = 1'b1;
    in_req = 16'h1000; in_lsb_first = 1'b0; step();
    in_req = 16'h0003; in_lsb_first = 1'b1; step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("flush_no_ghost", out_valid, 0);
    end
    single(16'h0040, 1'b0, "post_rst");

    // Randomized traffic with random gaps and random backpressure
    for (int c = 0; c < 120; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_req = 16'h0001 << $urandom_range(0, 15);
        1:       in_req = 16'h0000;
        2:       in_req = 16'($urandom) & 16'($urandom);
        default: in_req = 16'($urandom);
      endcase
      in_lsb_first = 1'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("random_drain");

    // WIDTH=64 instance: three-level tree
    run64(64'd1 << 37, 1'b0, "w64_bit37");
    run64(64'd1 << 37, 1'b1, "w64_bit37_lsb");
    run64(64'd0, 1'b0, "w64_zero");
    for (int i = 0; i < 6; i++) begin
      logic [63:0] r;
      r = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
      run64(r, 1'(i), "w64_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/prio_encoder_pipe.md
Name: prio_encoder_pipe

Overview:
- Parametrised, pipelined priority encoder. Next generation of the team's 4:2 / 16:4 encoder trees.
- Reduces a WIDTH-bit request vector to a binary index through a radix-4 tree of merge nodes, with one register stage per tree level.
- Adds over the combinational encoders: true priority resolution (not one-hot assumption), per-transaction priority direction, multi-hot detection, valid/ready flow control.
- Used in front of interrupt/arbitration logic needing an encoded winner at full clock rate.

Parameters:
- WIDTH, 16, request vector width; must be a power of 4 in 4..256. Any other value is an elaboration error.
- IDX_W, derived (log2(WIDTH)), output index width; not overridable.
- LEVELS, derived (log4(WIDTH)), number of tree levels, which equals the number of pipeline stages.

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request vector valid
- in_ready  output  1  block accepts input this cycle
- in_req  input  WIDTH  request bits; bit i = request i
- in_lsb_first  input  1  0: highest set index wins; 1: lowest set index wins
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_idx  output  IDX_W  winning index
- out_any  output  1  at least one request bit was set
- out_multi  output  1  more than one request bit was set

Behaviour:
- Single clock domain. Reset is synchronous and active-high; no asynchronous logic.
- Reset values: every stage valid flag = 0, out_valid = 0, out_idx = 0, out_any = 0, out_multi = 0.
- Datapath registers (not valid flags) may be left unreset internally, but the outputs must read 0 after reset.
- Handshake:
  - Global pipeline enable en = !out_valid | out_ready.
  - in_ready = en, combinational.
  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- Pipeline:
  - When en = 1, every stage advances. The stage-0 valid flag loads in_valid.
  - When en = 0, every stage holds, including bubbles. A stalled output must stay stable until accepted.
- Latency: exactly LEVELS cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 per cycle.
- in_lsb_first travels with its vector through every stage, so mixed-mode back-to-back vectors resolve independently.
- Leaf level: each request bit j forms a node with any = in_req[j], multi = 0, idx = empty.
- Merge node (4 children c3..c0 → parent):
  - any = |c.any.
  - multi = |c.multi, OR (number of children with any = 1) ≥ 2.
  - Winner w = highest child with any = 1 (lsb_first = 0) or lowest (lsb_first = 1).
  - idx = {w[1:0], c_w.idx}. The index grows 2 bits per level.
  - If no child has any set: w = 0, idx = 0.
- Zero vector: out_valid = 1, out_any = 0, out_idx = 0, out_multi = 0. An all-zero request is still a transaction.
- in_valid = 0 with en = 1: a bubble enters. in_req contents are don't-care.
- Reset mid-operation: all in-flight results are discarded. out_valid = 0 in the cycle after rst is sampled high. in_ready = 1 during and after reset.
- rst has priority over any simultaneous transfer.

Decomposition:
- Shared package / header prio_enc_pkg:
  - function clog4(n).
  - Node field widths: NODE_ANY = 1, NODE_MULTI = 1, per-level index width 2*L.
  - Constant MAX_WIDTH = 256.
- Sub-module prio_enc_node4:
  - Purely combinational 4-child merge.
  - Parameter CHILD_IDX_W (may be 0; handle via generate).
  - Input sel_lsb_first.
  - Instantiated WIDTH/4 + WIDTH/16 + … times by a generate loop per level. Each level is followed by a register bank gated by en.

Test Plan (WIDTH = 16, LEVELS = 2 unless stated):
1. Reset, then in_req = 16'h0100, lsb_first = 0, out_ready = 1 → 2 cycles later out_valid = 1, out_idx = 8, out_any = 1, out_multi = 0. Sweep all 16 one-hot values → out_idx = i each time.
2. in_req = 16'h8421, back-to-back with lsb_first = 0 then 1 → consecutive outputs idx = 15, multi = 1, then idx = 0, multi = 1. in_req = 16'h0030 → idx = 5 (msb-first) and 4 (lsb-first), multi = 1.
3. in_req = 16'h0000 → out_valid = 1, out_any = 0, out_idx = 0, out_multi = 0.
4. Stream 6 vectors while holding out_ready = 0 from cycle 3 for 4 cycles → in_ready = 0 while the output is held, out_idx stable, no vector lost or duplicated, order preserved after release.
5. Assert rst for 1 cycle with 2 vectors in flight → out_valid = 0 next cycle, nothing from the flushed vectors ever emerges. A new vector after reset appears with latency 2.
6. WIDTH = 64 (LEVELS = 3): in_req bit 37 only → out_idx = 37 after 3 cycles. Elaborating with WIDTH = 32 must fail.
